// File: rtl/acc_datapath.sv
// rtl/acc_datapath.sv - accumulator datapath responding to the accumulator controller
//
// Holds the accumulator (Acc), operand register (B) and iteration counter,
// and returns registered status to the controller.
//
// Ports:
//   CLK          system clock, all state changes on the rising edge
//   CLR          synchronous active-low reset
//   DIN          external operand / count input
//   AccParallel  load ALU result into Acc (wins over AccRight)
//   AccRight     arithmetic shift Acc right by one
//   ALUCtrl      ALU operation select
//   ASrc         ALU A source: 0 = Acc, 1 = zero
//   BSrc         ALU B source: 0 = B register, 1 = DIN
//   BLoad        load B register from DIN
//   CntLoad      load counter from DIN[CNT_W-1:0] (wins over CntDec)
//   CntDec       decrement counter, saturating at zero
//   ACC_OUT      current Acc value
//   Stat         {Acc[0], count == 0}
//   NFlag        Acc sign bit
//   OVF          signed overflow of the last Acc parallel write

module acc_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             AccParallel,
  input  logic             AccRight,
  input  logic [2:0]       ALUCtrl,
  input  logic             ASrc,
  input  logic             BSrc,
  input  logic             BLoad,
  input  logic             CntLoad,
  input  logic             CntDec,
  output logic [WIDTH-1:0] ACC_OUT,
  output logic [1:0]       Stat,
  output logic             NFlag,
  output logic             OVF
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] count;
  logic             cnt_zero;
  logic             ovf_reg;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [CNT_W-1:0] cnt_next;

  // ALU: B-side reads the stored B, so a BLoad in the same cycle is not seen
  always_comb begin
    alu_a   = ASrc ? '0 : acc;
    alu_b   = BSrc ? DIN : b_reg;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUCtrl)
      3'b000: begin
        alu_res = alu_a + alu_b;
        alu_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = alu_a - alu_b;
        alu_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a ^ alu_b;
      3'b101:  alu_res = alu_b;
      3'b110:  alu_res = ~alu_a;
      default: alu_res = alu_a;
    endcase
  end

  // Next count is computed here so the zero flag can be registered with it,
  // keeping Stat[0] a pure register output.
  always_comb begin
    cnt_next = count;
    if (CntLoad) begin
      cnt_next = DIN[CNT_W-1:0];
    end else if (CntDec && (count != '0)) begin
      cnt_next = count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      acc      <= '0;
      b_reg    <= '0;
      count    <= '0;
      cnt_zero <= 1'b1;
      ovf_reg  <= 1'b0;
    end else begin
      if (AccParallel) begin
        acc     <= alu_res;
        ovf_reg <= alu_ovf;
      end else if (AccRight) begin
        acc <= {acc[WIDTH-1], acc[WIDTH-1:1]};
      end
      if (BLoad) begin
        b_reg <= DIN;
      end
      count    <= cnt_next;
      cnt_zero <= (cnt_next == '0);
    end
  end

  assign ACC_OUT = acc;
  assign Stat    = {acc[0], cnt_zero};
  assign NFlag   = acc[WIDTH-1];
  assign OVF     = ovf_reg;

endmodule

// File: tb/tb_acc_datapath.sv
// tb/tb_acc_datapath.sv - scoreboard testbench for acc_datapath
//
// Drives one control word per cycle, pushes the expected status for that
// cycle into a queue, and pops/compares it one edge later.

module tb_acc_datapath;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] DIN;
  logic       AccParallel, AccRight, ASrc, BSrc, BLoad, CntLoad, CntDec;
  logic [2:0] ALUCtrl;
  logic [7:0] ACC_OUT;
  logic [1:0] Stat;
  logic       NFlag, OVF;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];   // {acc, zero, ovf}
  string      tag_q[$];

  acc_datapath #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .CLR(CLR), .DIN(DIN),
    .AccParallel(AccParallel), .AccRight(AccRight), .ALUCtrl(ALUCtrl),
    .ASrc(ASrc), .BSrc(BSrc), .BLoad(BLoad),
    .CntLoad(CntLoad), .CntDec(CntDec),
    .ACC_OUT(ACC_OUT), .Stat(Stat), .NFlag(NFlag), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ctl = {CLR, AccParallel, AccRight, ASrc, BSrc, BLoad, CntLoad, CntDec}
  task automatic step(input string tag, input logic [7:0] ctl, input logic [2:0] alu,
                      input logic [7:0] din, input logic [7:0] e_acc,
                      input logic e_zero, input logic e_ovf);
    logic [9:0] e;
    string      t;
    {CLR, AccParallel, AccRight, ASrc, BSrc, BLoad, CntLoad, CntDec} = ctl;
    ALUCtrl = alu;
    DIN     = din;
    exp_q.push_back({e_acc, e_zero, e_ovf});
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".acc"},   32'(ACC_OUT), 32'(e[9:2]));
    check({t, ".stat"},  32'(Stat),    32'({e[2], e[1]}));
    check({t, ".nflag"}, 32'(NFlag),   32'(e[9]));
    check({t, ".ovf"},   32'(OVF),     32'(e[0]));
  endtask

  // control word helpers
  localparam logic [7:0] IDLE = 8'b1000_0000;
  localparam logic [7:0] AP   = 8'b0100_0000;
  localparam logic [7:0] AR   = 8'b0010_0000;
  localparam logic [7:0] AS   = 8'b0001_0000;
  localparam logic [7:0] BS   = 8'b0000_1000;
  localparam logic [7:0] BL   = 8'b0000_0100;
  localparam logic [7:0] CL   = 8'b0000_0010;
  localparam logic [7:0] CD   = 8'b0000_0001;
  localparam logic [7:0] RST  = 8'b0000_0000;

  initial begin
    {CLR, AccParallel, AccRight, ASrc, BSrc, BLoad, CntLoad, CntDec} = 8'h00;
    ALUCtrl = 3'b000;
    DIN     = 8'h00;
    @(negedge CLK);

    // reset overrides active controls
    step("rst0",    RST | AP | BS | CL, 3'b101, 8'h55, 8'h00, 1'b1, 1'b0);
    step("rst1",    RST | AP | BS | CL, 3'b101, 8'h55, 8'h00, 1'b1, 1'b0);
    step("rel",     IDLE,               3'b000, 8'h55, 8'h00, 1'b1, 1'b0);

    // load / add
    step("bload5",  IDLE | BL,           3'b000, 8'h05, 8'h00, 1'b1, 1'b0);
    step("zero+3",  IDLE | AP | AS | BS, 3'b000, 8'h03, 8'h03, 1'b1, 1'b0);
    step("acc+b",   IDLE | AP,           3'b000, 8'h00, 8'h08, 1'b1, 1'b0);

    // BLoad in the same cycle as a parallel load: ALU sees old B (0x05)
    step("oldb",    IDLE | AP | BL,      3'b101, 8'h7F, 8'h05, 1'b1, 1'b0);
    step("newb",    IDLE | AP,           3'b101, 8'h00, 8'h7F, 1'b1, 1'b0);

    // overflow
    step("bload1",  IDLE | BL,           3'b000, 8'h01, 8'h7F, 1'b1, 1'b0);
    step("add_ov",  IDLE | AP,           3'b000, 8'h00, 8'h80, 1'b1, 1'b1);
    step("and_clr", IDLE | AP,           3'b010, 8'h00, 8'h00, 1'b1, 1'b0);

    // subtract edges
    step("0-1",     IDLE | AP,           3'b001, 8'h00, 8'hFF, 1'b1, 1'b0);
    step("set80",   IDLE | AP | BS,      3'b101, 8'h80, 8'h80, 1'b1, 1'b0);
    step("80-1",    IDLE | AP,           3'b001, 8'h00, 8'h7F, 1'b1, 1'b1);
    step("shr_ovh", IDLE | AR,           3'b000, 8'h00, 8'h3F, 1'b1, 1'b1);

    // shift and priority
    step("set81",   IDLE | AP | BS,      3'b101, 8'h81, 8'h81, 1'b1, 1'b0);
    step("shr1",    IDLE | AR,           3'b000, 8'h00, 8'hC0, 1'b1, 1'b0);
    step("shr2",    IDLE | AR,           3'b000, 8'h00, 8'hE0, 1'b1, 1'b0);
    step("set81b",  IDLE | AP | BS,      3'b101, 8'h81, 8'h81, 1'b1, 1'b0);
    step("prio",    IDLE | AP | AR | BS, 3'b101, 8'h10, 8'h10, 1'b1, 1'b0);

    // remaining ALU ops
    step("xor",     IDLE | AP | BS,      3'b100, 8'hFF, 8'hEF, 1'b1, 1'b0);
    step("and",     IDLE | AP | BS,      3'b010, 8'h0F, 8'h0F, 1'b1, 1'b0);
    step("or",      IDLE | AP | BS,      3'b011, 8'h30, 8'h3F, 1'b1, 1'b0);
    step("not",     IDLE | AP,           3'b110, 8'h00, 8'hC0, 1'b1, 1'b0);
    step("not0",    IDLE | AP | AS,      3'b110, 8'h00, 8'hFF, 1'b1, 1'b0);
    step("pass0",   IDLE | AP | AS,      3'b111, 8'h00, 8'h00, 1'b1, 1'b0);
    step("set80b",  IDLE | AP | BS,      3'b101, 8'h80, 8'h80, 1'b1, 1'b0);
    step("negov",   IDLE | AP | BS,      3'b000, 8'h80, 8'h00, 1'b1, 1'b1);
    step("idle_ov", IDLE,                3'b000, 8'h00, 8'h00, 1'b1, 1'b1);
    step("set5a",   IDLE | AP | BS,      3'b101, 8'h5A, 8'h5A, 1'b1, 1'b0);
    step("passa",   IDLE | AP,           3'b111, 8'h00, 8'h5A, 1'b1, 1'b0);

    // counter
    step("cl3",     IDLE | CL,           3'b000, 8'h03, 8'h5A, 1'b0, 1'b0);
    step("dec2",    IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b0, 1'b0);
    step("dec1",    IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b0, 1'b0);
    step("dec0",    IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b1, 1'b0);
    step("decsat",  IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b1, 1'b0);
    step("cl5dec",  IDLE | CL | CD,      3'b000, 8'h05, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("dec5",  IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b0, 1'b0);
    end
    step("dec_last",IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b1, 1'b0);
    step("clF0",    IDLE | CL,           3'b000, 8'hF0, 8'h5A, 1'b1, 1'b0);
    step("cl5",     IDLE | CL,           3'b000, 8'h05, 8'h5A, 1'b0, 1'b0);
    step("dec4",    IDLE | CD,           3'b000, 8'h00, 8'h5A, 1'b0, 1'b0);
    step("midrst",  RST | AP | BS | CD,  3'b101, 8'h33, 8'h00, 1'b1, 1'b0);
    step("postrst", IDLE | AP,           3'b000, 8'h00, 8'h00, 1'b1, 1'b0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
